// File: rtl/execute_pkg.sv
// Shared constants for the MIPS execute stage: funct/opcode codes, FSM states and control-bit indices.
package execute_pkg;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_DIVU = 6'h1B;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

  localparam int CTL_JUMP   = 0;
  localparam int CTL_BRANCH = 1;
  localparam int CTL_IMM    = 2;
  localparam int CTL_ALU    = 3;

  // Two's-complement overflow of r = a + b, from the sign bits only.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/execute_divider.sv
// Restoring radix-2 divider, one quotient bit per cycle, with signed fix-up and divide-by-zero handling.
module execute_divider
  import execute_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo, rem, dvs, dvd_raw;
  logic             neg_q, neg_r, div_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_shift, diff;
  logic [WIDTH-1:0] quo_step, rem_step;

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;

  // quo doubles as the dividend shift register: its MSB feeds the partial remainder.
  always_comb begin
    rem_shift = {rem, quo[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs};
    if (diff[WIDTH]) begin
      rem_step = rem_shift[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_step = diff[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      dvd_raw  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      count    <= CW'(WIDTH);
      quo      <= a_mag;
      rem      <= '0;
      dvs      <= b_mag;
      dvd_raw  <= dividend;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div_zero <= (divisor == '0);
    end else if (count != '0) begin
      count <= count - CW'(1);
      quo   <= quo_step;
      rem   <= rem_step;
    end
  end

  // The result is taken from the final step's combinational value so it lands on the last counting edge.
  assign done = (count == CW'(1));

  always_comb begin
    if (div_zero) begin
      quotient  = '1;
      remainder = dvd_raw;
    end else begin
      quotient  = neg_q ? -quo_step : quo_step;
      remainder = neg_r ? -rem_step : rem_step;
    end
  end

endmodule

// File: rtl/execute_unit.sv
// MIPS execute stage: single-cycle ALU/branch/jump plus HI/LO; iterative DIV/DIVU only when
// EXECUTE_DIV_EN is defined, otherwise DIV/DIVU report illegal.
//
// state | meaning
// IDLE  | accepting instructions, in_ready high
// DIV   | divider running, in_ready low until done
module execute_unit
  import execute_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [31:0]      insn,
  input  logic             alu_op,
  input  logic             alu_imm,
  input  logic             branch,
  input  logic             jump,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] next_pc,
  output logic             redirect,
  output logic             overflow,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);

  state_t state, state_next;

  logic             accept;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] imm, pc4, pc8, br_target, j_target;
  logic [WIDTH-1:0] sum, dif, sum_imm;
  logic [4:0]       shamt;
  logic [SW-1:0]    vshamt;
  logic [5:0]       funct;
  logic [WIDTH-1:0] res, npc;
  logic             redir, ovf, ill, is_div;
  logic             div_done;
  logic [WIDTH-1:0] div_quo, div_rem;
`ifdef EXECUTE_DIV_EN
  logic             div_start, div_signed;
`endif

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  assign funct     = insn[5:0];
  assign shamt     = insn[10:6];
  assign vshamt    = rs[SW-1:0];
  assign imm       = {{(WIDTH-16){insn[15]}}, insn[15:0]};
  assign pc4       = pc + WIDTH'(4);
  assign pc8       = pc + WIDTH'(8);
  assign br_target = pc4 + {imm[WIDTH-3:0], 2'b00};
  assign j_target  = {pc4[WIDTH-1:28], insn[25:0], 2'b00};
  assign sum       = rs + rt;
  assign dif       = rs - rt;
  assign sum_imm   = rs + imm;

  always_comb begin
    res    = '0;
    npc    = pc4;
    redir  = 1'b0;
    ovf    = 1'b0;
    ill    = 1'b0;
    is_div = 1'b0;
`ifdef EXECUTE_DIV_EN
    div_signed = 1'b0;
`endif
    if (alu_op) begin
      case (funct)
        FN_ADD: begin
          res = sum;
          ovf = add_ovf(rs[WIDTH-1], rt[WIDTH-1], sum[WIDTH-1]);
        end
        FN_ADDU: res = sum;
        FN_SUB: begin
          res = dif;
          ovf = add_ovf(rs[WIDTH-1], ~rt[WIDTH-1], dif[WIDTH-1]);
        end
        FN_SUBU: res = dif;
        FN_AND:  res = rs & rt;
        FN_OR:   res = rs | rt;
        FN_XOR:  res = rs ^ rt;
        FN_NOR:  res = ~(rs | rt);
        FN_SLT:  res = WIDTH'($signed(rs) < $signed(rt));
        FN_SLTU: res = WIDTH'(rs < rt);
        FN_SLL:  res = rt << shamt;
        FN_SRL:  res = rt >> shamt;
        FN_SRA:  res = $signed(rt) >>> shamt;
        FN_SLLV: res = rt << vshamt;
        FN_SRLV: res = rt >> vshamt;
        FN_SRAV: res = $signed(rt) >>> vshamt;
        FN_MFHI: res = hi;
        FN_MFLO: res = lo;
        FN_JR: begin
          npc   = rs;
          redir = 1'b1;
        end
        FN_JALR: begin
          npc   = rs;
          redir = 1'b1;
          res   = pc8;
        end
        FN_DIV, FN_DIVU: begin
`ifdef EXECUTE_DIV_EN
          is_div     = 1'b1;
          div_signed = (funct == FN_DIV);
`else
          ill = 1'b1;
`endif
        end
        default: ill = 1'b1;
      endcase
    end else if (alu_imm) begin
      res = sum_imm;
      ovf = add_ovf(rs[WIDTH-1], imm[WIDTH-1], sum_imm[WIDTH-1]);
    end else if (branch) begin
      npc = br_target;
      if (insn[31:26] == OP_BEQ)      redir = (rs == rt);
      else if (insn[31:26] == OP_BNE) redir = (rs != rt);
    end else if (jump) begin
      npc   = j_target;
      redir = 1'b1;
      res   = pc8;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
`ifdef EXECUTE_DIV_EN
    div_start  = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef EXECUTE_DIV_EN
        if (accept && is_div) begin
          state_next = DIV;
          div_start  = 1'b1;
        end
`endif
      end
`ifdef EXECUTE_DIV_EN
      DIV: if (div_done) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

`ifdef EXECUTE_DIV_EN
  execute_divider #(.WIDTH(WIDTH)) u_divider (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .is_signed (div_signed),
    .dividend  (rs),
    .divisor   (rt),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`else
  assign div_done = 1'b0;
  assign div_quo  = '0;
  assign div_rem  = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      next_pc   <= '0;
      redirect  <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= accept && !is_div;
      if (accept && !is_div) begin
        data_out <= res;
        next_pc  <= npc;
        redirect <= redir;
        overflow <= ovf;
        illegal  <= ill;
      end
      if (div_done) begin
        hi <= div_rem;
        lo <= div_quo;
      end
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit (WIDTH=32); DIV checks follow EXECUTE_DIV_EN.
`timescale 1ns/1ps
module tb_execute_unit;

  localparam logic [3:0] C_ALU = 4'b1000;
  localparam logic [3:0] C_IMM = 4'b0100;
  localparam logic [3:0] C_BR  = 4'b0010;
  localparam logic [3:0] C_J   = 4'b0001;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pc = '0, rs = '0, rt = '0, insn = '0;
  logic        alu_op = 1'b0, alu_imm = 1'b0, branch = 1'b0, jump = 1'b0;
  logic        out_valid;
  logic [31:0] data_out, next_pc;
  logic        redirect, overflow, illegal;

  execute_unit #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pc        (pc),
    .rs        (rs),
    .rt        (rt),
    .insn      (insn),
    .alu_op    (alu_op),
    .alu_imm   (alu_imm),
    .branch    (branch),
    .jump      (jump),
    .out_valid (out_valid),
    .data_out  (data_out),
    .next_pc   (next_pc),
    .redirect  (redirect),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [31:0] npc;
    logic        redir;
    logic        chk_npc;
    logic        ovf;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input string n, input logic [31:0] d, input logic [31:0] np,
                              input logic r, input logic c, input logic o, input logic i);
    exp_t e;
    e.name = n; e.data = d; e.npc = np; e.redir = r; e.chk_npc = c; e.ovf = o; e.ill = i;
    return e;
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 5'd0, 5'd0, 5'd0, sh, fn};
  endfunction

  always @(negedge clock) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_valid=1 required 0 (nothing pending)");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "/data"}, data_out, e.data);
        check({e.name, "/redirect"}, 32'(redirect), 32'(e.redir));
        check({e.name, "/overflow"}, 32'(overflow), 32'(e.ovf));
        check({e.name, "/illegal"}, 32'(illegal), 32'(e.ill));
        if (e.chk_npc) check({e.name, "/next_pc"}, next_pc, e.npc);
      end
    end
  end

  task automatic send(input string n, input logic [3:0] ctl, input logic [31:0] insn_v,
                      input logic [31:0] rs_v, input logic [31:0] rt_v, input logic [31:0] pc_v,
                      input bit has_out, input exp_t e);
    int waited;
    waited = 0;
    @(negedge clock);
    while (!in_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_ready_timeout: in_ready=0 required 1", n);
    end else begin
      {alu_op, alu_imm, branch, jump} = ctl;
      insn = insn_v; rs = rs_v; rt = rt_v; pc = pc_v;
      in_valid = 1'b1;
      if (has_out) sb.push_back(e);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      {alu_op, alu_imm, branch, jump} = 4'b0000;
    end
  endtask

  exp_t none;
  int   low;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    none = mk("none", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset/in_ready", 32'(in_ready), 32'd1);
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/data_out", data_out, 32'h0);
    check("reset/next_pc", next_pc, 32'h0);
    check("reset/flags", {29'd0, redirect, overflow, illegal}, 32'h0);

    send("add_ovf", C_ALU, rtype(6'h20, 0), 32'h7FFFFFFF, 32'h1, 32'h0, 1,
         mk("add_ovf", 32'h80000000, 0, 0, 0, 1, 0));
    @(negedge clock);
    @(negedge clock);
    check("out_valid_pulse", 32'(out_valid), 32'd0);

    send("addu", C_ALU, rtype(6'h21, 0), 32'h7FFFFFFF, 32'h1, 0, 1,
         mk("addu", 32'h80000000, 0, 0, 0, 0, 0));
    send("sub_ovf", C_ALU, rtype(6'h22, 0), 32'h80000000, 32'h1, 0, 1,
         mk("sub_ovf", 32'h7FFFFFFF, 0, 0, 0, 1, 0));
    send("sra", C_ALU, rtype(6'h03, 5'd4), 32'h0, 32'h80000010, 0, 1,
         mk("sra", 32'hF8000001, 0, 0, 0, 0, 0));
    send("sllv", C_ALU, rtype(6'h04, 0), 32'd33, 32'h1, 0, 1,
         mk("sllv", 32'h2, 0, 0, 0, 0, 0));
    send("srl", C_ALU, rtype(6'h02, 5'd8), 32'h0, 32'h80000000, 0, 1,
         mk("srl", 32'h00800000, 0, 0, 0, 0, 0));
    send("slt", C_ALU, rtype(6'h2A, 0), 32'hFFFFFFFF, 32'h1, 0, 1,
         mk("slt", 32'h1, 0, 0, 0, 0, 0));
    send("sltu", C_ALU, rtype(6'h2B, 0), 32'hFFFFFFFF, 32'h1, 0, 1,
         mk("sltu", 32'h0, 0, 0, 0, 0, 0));
    send("nor", C_ALU, rtype(6'h27, 0), 32'h0F0F0000, 32'h000000F0, 0, 1,
         mk("nor", 32'hF0F0FF0F, 0, 0, 0, 0, 0));
    send("xor", C_ALU, rtype(6'h26, 0), 32'hFF00FF00, 32'h0FF00FF0, 0, 1,
         mk("xor", 32'hF0F0F0F0, 0, 0, 0, 0, 0));
    send("addi_neg", C_IMM, 32'h2000FFFF, 32'd5, 32'h0, 0, 1,
         mk("addi_neg", 32'h4, 0, 0, 0, 0, 0));
    send("addi_ovf", C_IMM, 32'h20000001, 32'h7FFFFFFF, 32'h0, 0, 1,
         mk("addi_ovf", 32'h80000000, 0, 0, 0, 1, 0));
    send("beq_taken", C_BR, 32'h1000FFFF, 32'h55, 32'h55, 32'h100, 1,
         mk("beq_taken", 32'h0, 32'h100, 1, 1, 0, 0));
    send("bne_not", C_BR, 32'h1400FFFF, 32'h55, 32'h55, 32'h100, 1,
         mk("bne_not", 32'h0, 0, 0, 0, 0, 0));
    send("bne_taken", C_BR, 32'h14000010, 32'h1, 32'h2, 32'h200, 1,
         mk("bne_taken", 32'h0, 32'h244, 1, 1, 0, 0));
    send("jump", C_J, 32'h08000040, 0, 0, 32'h10000000, 1,
         mk("jump", 32'h10000008, 32'h10000100, 1, 1, 0, 0));
    send("jalr", C_ALU, rtype(6'h09, 0), 32'h2000, 32'h0, 32'h300, 1,
         mk("jalr", 32'h308, 32'h2000, 1, 1, 0, 0));
    send("jr", C_ALU, rtype(6'h08, 0), 32'h4444, 32'h0, 32'h300, 1,
         mk("jr", 32'h0, 32'h4444, 1, 1, 0, 0));
    send("priority", C_ALU | C_J, rtype(6'h21, 0), 32'd2, 32'd3, 32'h0, 1,
         mk("priority", 32'd5, 0, 0, 0, 0, 0));
    send("illegal", C_ALU, rtype(6'h3F, 0), 32'h1234, 32'h5678, 0, 1,
         mk("illegal", 32'h0, 0, 0, 0, 0, 1));

`ifdef EXECUTE_DIV_EN
    send("div_neg", C_ALU, rtype(6'h1A, 0), 32'hFFFFFFF9, 32'h2, 0, 0, none);
    low = 0;
    @(negedge clock);
    while (!in_ready && low < 100) begin
      low++;
      @(negedge clock);
    end
    check("div_busy_cycles", 32'(low), 32'd32);
    send("mflo_div", C_ALU, rtype(6'h12, 0), 0, 0, 0, 1,
         mk("mflo_div", 32'hFFFFFFFD, 0, 0, 0, 0, 0));
    send("mfhi_div", C_ALU, rtype(6'h10, 0), 0, 0, 0, 1,
         mk("mfhi_div", 32'hFFFFFFFF, 0, 0, 0, 0, 0));
    send("div_mn", C_ALU, rtype(6'h1A, 0), 32'h80000000, 32'hFFFFFFFF, 0, 0, none);
    send("mflo_mn", C_ALU, rtype(6'h12, 0), 0, 0, 0, 1,
         mk("mflo_mn", 32'h80000000, 0, 0, 0, 0, 0));
    send("mfhi_mn", C_ALU, rtype(6'h10, 0), 0, 0, 0, 1,
         mk("mfhi_mn", 32'h0, 0, 0, 0, 0, 0));
    send("divu_zero", C_ALU, rtype(6'h1B, 0), 32'd7, 32'd0, 0, 0, none);
    send("mflo_z", C_ALU, rtype(6'h12, 0), 0, 0, 0, 1,
         mk("mflo_z", 32'hFFFFFFFF, 0, 0, 0, 0, 0));
    send("mfhi_z", C_ALU, rtype(6'h10, 0), 0, 0, 0, 1,
         mk("mfhi_z", 32'd7, 0, 0, 0, 0, 0));
    send("div_abort", C_ALU, rtype(6'h1B, 0), 32'd100, 32'd3, 0, 0, none);
    repeat (10) @(posedge clock);
    @(negedge clock);
    check("div_abort/busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("div_abort/in_ready", 32'(in_ready), 32'd1);
    send("mfhi_abort", C_ALU, rtype(6'h10, 0), 0, 0, 0, 1,
         mk("mfhi_abort", 32'h0, 0, 0, 0, 0, 0));
    send("mflo_abort", C_ALU, rtype(6'h12, 0), 0, 0, 0, 1,
         mk("mflo_abort", 32'h0, 0, 0, 0, 0, 0));
`else
    send("div_off", C_ALU, rtype(6'h1A, 0), 32'hFFFFFFF9, 32'h2, 0, 1,
         mk("div_off", 32'h0, 0, 0, 0, 0, 1));
    send("divu_off", C_ALU, rtype(6'h1B, 0), 32'd7, 32'd0, 0, 1,
         mk("divu_off", 32'h0, 0, 0, 0, 0, 1));
    low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!in_ready) low++;
    end
    check("div_off/ready_low_cycles", 32'(low), 32'd0);
    send("mfhi_off", C_ALU, rtype(6'h10, 0), 0, 0, 0, 1,
         mk("mfhi_off", 32'h0, 0, 0, 0, 0, 0));
    send("mflo_off", C_ALU, rtype(6'h12, 0), 0, 0, 0, 1,
         mk("mflo_off", 32'h0, 0, 0, 0, 0, 0));
`endif

    repeat (3) @(negedge clock);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_unit.md
# execute_unit

Parametrised execute stage for the MIPS pipeline. It sits between decode and memory and takes register operands, the instruction word and decoded control bits. It produces the ALU result, the next-PC redirect and the HI/LO state. It adds the missing shift, logic, compare and MFHI/MFLO operations, plus an iterative multi-cycle DIV/DIVU behind a valid/ready handshake.

## Interface
- WIDTH, 32: datapath width; allowed values are 32 and 64. The instruction is always 32 bits.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  unit accepts; equals (state==IDLE).
- pc  in  WIDTH  address of the instruction.
- rs, rt  in  WIDTH  register operands. rs is ALU operand A; B is rt or the immediate.
- insn  in  32  instruction. MIPS bit numbering, bit 31 is the MSB.
- alu_op  in  1  R-type: decode funct insn[5:0].
- alu_imm  in  1  B = sign-extended insn[15:0] (ADDI-class; the result is A+B).
- branch  in  1  BEQ/BNE, selected by opcode insn[31:26].
- jump  in  1  J/JAL target.
- out_valid  out  1  single-cycle pulse: data_out/next_pc/redirect are valid.
- data_out  out  WIDTH  registered result.
- next_pc  out  WIDTH  registered redirect target.
- redirect  out  1  next_pc must be taken.
- overflow  out  1  signed overflow on ADD/SUB/ADDI; the result still wraps.
- illegal  out  1  unsupported funct with alu_op set.

## Operation
- Acceptance: in_valid && in_ready at a rising edge. Exactly one control bit is set; if several are set, the priority is alu_op > alu_imm > branch > jump.
- ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR: WIDTH-bit wrap. overflow is set only for ADD/SUB/ADDI.
- SLT is signed; SLTU is unsigned. The result is 0 or 1, zero-extended.
- SLL/SRL/SRA shift rt by insn[10:6]. SLLV/SRLV/SRAV shift rt by rs[log2(WIDTH)-1:0]. SRA fills with rt's sign bit.
- MFHI/MFLO: data_out = HI/LO.
- JR: redirect to rs.
- JALR: redirect to rs; data_out = pc+8.
- Branch target is pc+4+(sext(imm)<<2). The branch is taken when BEQ and rs==rt, or BNE and rs!=rt. redirect = taken.
- Jump: next_pc = {(pc+4)[WIDTH-1:28], insn[25:0], 2'b00}; data_out = pc+8.
- Unsupported funct: illegal=1, data_out=0, no state change.
- DIV/DIVU: the FSM goes IDLE -> DIV. A counter loads WIDTH and decrements each cycle. When it reaches 0, LO=quotient and HI=remainder, and the FSM returns to IDLE.
- DIV/DIVU produce no out_valid.
- Signed division divides magnitudes. The quotient is negated when the signs differ; the remainder takes the sign of the dividend.
- Divide by zero: LO = all ones, HI = dividend. Same latency.
- Most-negative / -1: LO = most-negative, HI = 0.

## Timing
- Reset values: in_ready=1 and state=IDLE. out_valid, data_out, next_pc, redirect, overflow, illegal, HI and LO are all 0.
- Single-cycle ops: accepted at edge E. Outputs are registered at E and visible in the following cycle. out_valid is high for exactly one cycle unless a new op is accepted at E+1.
- Back-to-back acceptance is allowed every cycle while in IDLE.
- DIV accepted at E0 drops in_ready from E0 through E0+WIDTH. HI/LO update at E0+WIDTH. A MFHI can be accepted at E0+WIDTH+1 and sees the new value.
- in_valid while busy: held off by in_ready=0. Inputs are ignored, and decode must hold them.
- Reset during DIV aborts the division: HI/LO=0 and the FSM returns to IDLE on the next edge.
- overflow and illegal are qualified by out_valid.

## Configuration
- EXECUTE_DIV_EN defined: DIV/DIVU are implemented as above.
- EXECUTE_DIV_EN undefined: there is no DIV state and no divider instance.
- Without it, DIV/DIVU set illegal with out_valid, HI/LO never change, and in_ready stays 1 outside reset.

## Structure
- Package execute_pkg holds:
  - funct and opcode localparams (ADD..NOR, SLT/SLTU, shifts, MFHI/MFLO, JR/JALR, DIV/DIVU, BEQ/BNE, J/JAL);
  - the state enum {IDLE, DIV};
  - the control-bit index constants.
- Sub-module execute_divider, parametrised by WIDTH:
  - restoring radix-2 divider, one bit per cycle;
  - start/done handshake and a signed flag.
  - It owns the counter; the top FSM waits on done.

## Test plan
- Reset, then ADD rs=0x7FFFFFFF, rt=1 -> data_out=0x80000000, overflow=1, out_valid for 1 cycle. ADDU with the same operands -> overflow=0.
- SRA rt=0x80000010 shamt=4 -> 0xF8000001. SLLV rs=33 rt=1 -> 2 (shift amount masked to 5 bits).
- SLT rs=0xFFFFFFFF rt=1 -> 1. SLTU with the same operands -> 0. BEQ pc=0x100, imm=-1, rs==rt -> redirect=1, next_pc=0x100.
- DIV rs=-7 rt=2 (WIDTH=32) -> in_ready low 32 cycles, then MFLO=0xFFFFFFFD and MFHI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
- Reset asserted 10 cycles into a DIV -> in_ready=1 next cycle; MFHI returns 0.
- funct 0x3F with alu_op -> illegal=1, data_out=0. Build without EXECUTE_DIV_EN, DIV -> illegal=1, in_ready never drops.
